// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// Single-bit half adder. This is the leaf primitive for wider ripple and
// compressor structures in the arithmetic datapath. It provides:
//   * a zero-latency combinational sum/carry (s, c)
//   * a registered, valid-qualified copy of that result (s_q, c_q, out_valid)
//   * optionally, a saturating count of accepted carry events
//
// Optional feature macro: HALF_ADDER_STATS_EN
//   When defined, the cnt_clr input, the carry_cnt output and a CNT_W-bit
//   saturating counter are built. When it is undefined, those ports and the
//   counter do not exist and CNT_W has no effect.
//
// Parameters:
//   CNT_W      width of the carry-event counter (legal range 2..32)
//
// Ports:
//   clk        datapath clock; all state updates on its rising edge
//   rst_n      asynchronous active-low reset (release synchronous to clk)
//   a, b       addends
//   in_valid   qualifies a/b for the registered path and the counter
//   s, c       combinational sum (a ^ b) and carry (a & b)
//   s_q, c_q   registered sum and carry; held while in_valid is low
//   out_valid  s_q/c_q carry a fresh result this cycle
//   cnt_clr    synchronous clear of carry_cnt (HALF_ADDER_STATS_EN only)
//   carry_cnt  number of accepted carry events (HALF_ADDER_STATS_EN only)
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic             s,
  output logic             c,
  output logic             s_q,
  output logic             c_q,
  output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + CNT_W'(1);
    end
    return res;
  endfunction

  // ---- Stage p0: combinational sum/carry ------------------------------------
  logic sum_p0;
  logic carry_p0;
  logic vld_p0;

  always_comb begin
    sum_p0   = a ^ b;
    carry_p0 = a & b;
    vld_p0   = in_valid;
  end

  assign s = sum_p0;
  assign c = carry_p0;

  // ---- Stage p1: registered result ------------------------------------------
  logic sum_p1;
  logic carry_p1;
  logic vld_p1;

  // The data registers are reset as well because the result must read as
  // 0/0 while rst_n is low; they only load when the input is qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1   <= 1'b0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        sum_p1   <= sum_p0;
        carry_p1 <= carry_p0;
      end
    end
  end

  assign s_q       = sum_p1;
  assign c_q       = carry_p1;
  assign out_valid = vld_p1;

`ifdef HALF_ADDER_STATS_EN
  // ---- Stage p1: carry-event counter ----------------------------------------
  logic [CNT_W-1:0] cnt_p1;

  // Clear has priority over a same-cycle counted carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (cnt_clr) begin
      cnt_p1 <= '0;
    end else if (vld_p0 && carry_p0) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign carry_cnt = cnt_p1;
`else
  // Without the statistics feature the counter width only sizes this tie-off
  // and the unused saturation helper.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = sat_inc('0) & '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//
// Self-checking bench for half_adder. Registered results are predicted when
// stimulus is driven (pushed to a queue) and compared when the DUT presents
// them one edge later. With HALF_ADDER_STATS_EN defined, a second instance
// with CNT_W=2 shares the stimulus so saturation can be reached quickly.
// -----------------------------------------------------------------------------
module tb_half_adder;

  typedef struct {
    logic s;
    logic c;
    logic v;
  } exp_t;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic in_valid;
  logic cnt_clr;
  logic s;
  logic c;
  logic s_q;
  logic c_q;
  logic out_valid;
  logic clk_run;

  int errors;
  int checks;

  exp_t exp_q[$];
  exp_t e;
  logic m_s;
  logic m_c;
  int   m_cnt16;
  int   m_cnt2;

`ifdef HALF_ADDER_STATS_EN
  logic [15:0] carry_cnt;
  logic [1:0]  carry_cnt2;
  logic        s2, c2, s_q2, c_q2, out_valid2;
`endif

  half_adder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .c         (c),
    .s_q       (s_q),
    .c_q       (c_q),
    .out_valid (out_valid)
`ifdef HALF_ADDER_STATS_EN
    ,
    .cnt_clr   (cnt_clr),
    .carry_cnt (carry_cnt)
`endif
  );

`ifdef HALF_ADDER_STATS_EN
  half_adder #(.CNT_W(2)) sat_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s2),
    .c         (c2),
    .s_q       (s_q2),
    .c_q       (c_q2),
    .out_valid (out_valid2),
    .cnt_clr   (cnt_clr),
    .carry_cnt (carry_cnt2)
  );
`endif

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus at the falling edge, record the prediction,
  // and return 1 time unit after the following rising edge.
  task automatic drive(input logic va, input logic vb, input logic vv, input logic vclr);
    exp_t x;
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = vv;
    cnt_clr = vclr;
    if (vv) begin
      m_s = va ^ vb;
      m_c = va & vb;
    end
    x.s = m_s;
    x.c = m_c;
    x.v = vv;
    exp_q.push_back(x);
    if (vclr) begin
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else if (vv && va && vb) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    in_valid = 1'b1;
    cnt_clr = 1'b0;
    #1;
    checks++;
    if ({s_q, c_q, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_regs: got s_q,c_q,out_valid=%b required 000", {s_q, c_q, out_valid});
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d required 0", carry_cnt);
    end
`endif
  endtask

  task automatic test_comb;
    logic [1:0] ab_tab[4];
    logic [1:0] sc_tab[4];
    ab_tab = '{2'b11, 2'b01, 2'b10, 2'b00};
    sc_tab = '{2'b01, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      a = ab_tab[i][1];
      b = ab_tab[i][0];
      #10;
      checks++;
      if ({s, c} !== sc_tab[i]) begin
        errors++;
        $display("FAIL comb_ab%b: got s,c=%b required %b", ab_tab[i], {s, c}, sc_tab[i]);
      end
    end
  endtask

  task automatic start_clock;
    in_valid = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_s = 1'b0;
    m_c = 1'b0;
    m_cnt16 = 0;
    m_cnt2 = 0;
  endtask

  task automatic test_latency;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({s_q, c_q, out_valid} !== 3'b011 || {e.s, e.c, e.v} !== 3'b011) begin
      errors++;
      $display("FAIL latency_valid: got s_q,c_q,out_valid=%b required 011", {s_q, c_q, out_valid});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({s_q, c_q, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL latency_hold: got s_q,c_q,out_valid=%b required 010", {s_q, c_q, out_valid});
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] pat[8];
    pat = '{3'b111, 3'b011, 3'b101, 3'b001, 3'b110, 3'b100, 3'b000, 3'b011};
    for (int i = 0; i < 8; i++) begin
      drive(pat[i][2], pat[i][1], pat[i][0], 1'b0);
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL b2b_queue%0d: got empty queue required one entry", i);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({s_q, c_q, out_valid} !== {e.s, e.c, e.v}) begin
          errors++;
          $display("FAIL b2b_%0d: got s_q,c_q,out_valid=%b required %b",
                   i, {s_q, c_q, out_valid}, {e.s, e.c, e.v});
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({s_q, c_q, out_valid} !== {e.s, e.c, e.v}) begin
      errors++;
      $display("FAIL pre_reset: got %b required %b", {s_q, c_q, out_valid}, {e.s, e.c, e.v});
    end
    #2;
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b0;
    #1;
    checks++;
    if ({s_q, c_q, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_regs: got s_q,c_q,out_valid=%b required 000", {s_q, c_q, out_valid});
    end
    checks++;
    if ({s, c} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_comb: got s,c=%b required 10", {s, c});
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d required 0", carry_cnt);
    end
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_s = 1'b0;
    m_c = 1'b0;
    m_cnt16 = 0;
    m_cnt2 = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({s_q, c_q, out_valid} !== 3'b101 || {e.s, e.c, e.v} !== 3'b101) begin
      errors++;
      $display("FAIL post_reset: got s_q,c_q,out_valid=%b required 101", {s_q, c_q, out_valid});
    end
  endtask

  task automatic test_invalid;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({s_q, c_q, out_valid} !== {e.s, e.c, 1'b0}) begin
        errors++;
        $display("FAIL invalid_hold%0d: got s_q,c_q,out_valid=%b required %b",
                 i, {s_q, c_q, out_valid}, {e.s, e.c, 1'b0});
      end
      checks++;
      if (c !== 1'b1) begin
        errors++;
        $display("FAIL invalid_comb_c%0d: got %b required 1", i, c);
      end
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt !== 16'(m_cnt16)) begin
      errors++;
      $display("FAIL invalid_cnt: got %0d required %0d", carry_cnt, m_cnt16);
    end
`endif
  endtask

`ifdef HALF_ADDER_STATS_EN
  task automatic test_counter;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0 || i == 7) drive(1'b1, 1'b1, 1'b1, 1'b0);
      else drive(1'b1, 1'b0, 1'b1, 1'b0);
    end
    exp_q.delete();
    checks++;
    if (carry_cnt !== 16'd5 || m_cnt16 != 5) begin
      errors++;
      $display("FAIL cnt_accum: got %0d required 5", carry_cnt);
    end
  endtask

  task automatic test_saturation;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (carry_cnt2 !== 2'(m_cnt2)) begin
        errors++;
        $display("FAIL cnt_sat_step%0d: got %0d required %0d", i, carry_cnt2, m_cnt2);
      end
    end
    checks++;
    if (carry_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL cnt_sat: got %0d required 3", carry_cnt2);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (carry_cnt2 !== 2'd0 || carry_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clr_wins: got %0d/%0d required 0/0", carry_cnt2, carry_cnt);
    end
    exp_q.delete();
    cnt_clr = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    clk_run = 1'b0;
    m_s = 1'b0;
    m_c = 1'b0;
    m_cnt16 = 0;
    m_cnt2 = 0;
    test_reset();
    test_comb();
    start_clock();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
`ifdef HALF_ADDER_STATS_EN
    test_counter();
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/half_adder.md
# half_adder

Single-bit half adder for the arithmetic datapath. It provides a zero-latency combinational sum/carry and a registered, valid-qualified copy of the same result. An optional saturating carry-event counter supports datapath statistics. The block is the leaf primitive used by wider ripple and compressor structures, and it is clocked with the rest of the datapath domain.

## Interface
Parameters:
- CNT_W, default 16: width of the carry-event counter. Legal range is 2..32.

Ports:
- clk, input, 1: datapath clock. All state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low. Assertion takes effect immediately. Release is synchronous to clk.
- a, input, 1: addend A.
- b, input, 1: addend B.
- in_valid, input, 1: qualifies a/b for the registered path.
- s, output, 1: combinational sum, a XOR b.
- c, output, 1: combinational carry, a AND b.
- s_q, output, 1: registered sum.
- c_q, output, 1: registered carry.
- out_valid, output, 1: s_q/c_q hold a fresh result this cycle.
- cnt_clr, input, 1: synchronous clear of carry_cnt. Present only with HALF_ADDER_STATS_EN.
- carry_cnt, output, CNT_W: number of accepted carry events. Present only with HALF_ADDER_STATS_EN.

## Operation
- Combinational path:
  - s = a ^ b and c = a & b at all times, independent of clk, rst_n and in_valid.
  - Truth table (a,b -> s,c): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Registered path:
  - On a rising clk edge with in_valid=1: s_q <= a^b, c_q <= a&b, out_valid <= 1.
  - On a rising clk edge with in_valid=0: s_q and c_q hold their previous value, out_valid <= 0.
- Carry counter (HALF_ADDER_STATS_EN only):
  - On each rising edge with in_valid=1 and a&b=1, carry_cnt increments by 1.
  - carry_cnt saturates at 2^CNT_W-1. It never wraps.
  - cnt_clr=1 sets carry_cnt to 0 on the next edge. When cnt_clr and a counted carry occur in the same cycle, the clear wins and carry_cnt becomes 0.
- No X propagation: every output is defined whenever the inputs are 0 or 1.

## Timing
- s and c have zero-cycle latency. They settle within the same timestep as an input change.
- s_q, c_q and out_valid have one-cycle latency: inputs sampled at edge N appear after edge N.
- Reset values while rst_n=0: s_q=0, c_q=0, out_valid=0, carry_cnt=0. s and c keep following a and b during reset.
- Asserting reset mid-stream discards any in-flight result. The first edge after release with in_valid=1 produces out_valid=1 one cycle later.
- There is no backpressure. Every valid input is accepted on every cycle.

## Configuration
- HALF_ADDER_STATS_EN:
  - Defined: cnt_clr, carry_cnt and the CNT_W-bit saturating counter are built.
  - Undefined: these ports and the counter logic are absent, CNT_W is ignored, and all other behaviour is unchanged.

## Test plan
- Combinational truth table: apply a,b = 11, 01, 10, 00, waiting 10 time units each with no clock activity. Required s,c = 0,1; 1,0; 1,0; 0,0 respectively.
- Registered latency: in_valid=1 with a=1,b=1 at edge N. Required s_q=0, c_q=1, out_valid=1 after edge N. Drop in_valid at edge N+1: required out_valid=0, with s_q/c_q held at 0/1.
- Reset mid-operation: assert rst_n=0 between edges while out_valid=1. Required s_q=0, c_q=0, out_valid=0 immediately. s tracks a=1,b=0 as 1 during reset.
- Counter accumulate (STATS_EN, CNT_W=16): 5 valid cycles of a=b=1 interleaved with 3 valid cycles of a=1,b=0. Required carry_cnt=5.
- Saturation and clear (STATS_EN, CNT_W=2): 6 valid carries give carry_cnt=3. Then cnt_clr=1 together with a valid carry gives carry_cnt=0.
- Invalid inputs not counted: in_valid=0 with a=b=1 for 4 cycles. Required carry_cnt unchanged and out_valid=0, while c=1 combinationally.
